// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_t  - sequencer states (IDLE, ACCESS, RESP)
//   requester_t  - which client owns the port (FETCH, DATA)
//   LAT_W        - width of the wait-cycle counter
//   lat_load     - converts a latency in cycles to the counter preload value
`timescale 1ns/1ps
package mem_arb_pkg;

  localparam int LAT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} arb_state_t;
  typedef enum logic {FETCH, DATA} requester_t;

  // The counter runs LAT-1 down to 0, giving exactly LAT ACCESS cycles.
  function automatic logic [LAT_W-1:0] lat_load(input int lat);
    return LAT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// mem_wait_counter: loadable down-counter that times memory wait cycles.
//   clock, reset  - clock and asynchronous active-high reset
//   load          - preload count with load_value (has priority over enable)
//   load_value    - preload value
//   enable        - decrement by one per cycle, saturating at zero
//   zero          - count is zero
`timescale 1ns/1ps
module mem_wait_counter
  import mem_arb_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [LAT_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [LAT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences the single shared memory port between the
// instruction-fetch path and the load/store path.
//   clock, reset        - clock and asynchronous active-high reset
//   if_req/if_addr      - fetch request (held until if_done) and address
//   if_done/if_rdata    - one-cycle completion pulse and registered fetch data
//   d_req/d_we/d_addr/d_wdata - load/store request, direction, address, data
//   d_done/d_rdata      - one-cycle completion pulse and registered load data
//   mem_addr/mem_wdata/mem_wr - memory port, held for the access latency
//   mem_rdata           - memory read data, captured on the last ACCESS edge
//   busy                - high whenever the sequencer is not IDLE
// Ties in IDLE go to the requester that was not granted last.
`timescale 1ns/1ps
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int READ_LAT  = 3,
  parameter int WRITE_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_MAX = (1 << LAT_W) - 1;

  if (READ_LAT < 1 || READ_LAT > LAT_MAX || WRITE_LAT < 1 || WRITE_LAT > LAT_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: READ_LAT and WRITE_LAT must be in 1..15");
  end

  localparam logic [LAT_W-1:0] READ_LOAD  = lat_load(READ_LAT);
  localparam logic [LAT_W-1:0] WRITE_LOAD = lat_load(WRITE_LAT);

  arb_state_t        state, next_state;
  requester_t        last_grant, grant_sel;
  logic              grant;
  logic              cnt_zero;
  logic [LAT_W-1:0]  load_value;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_sel  = last_grant;
    busy       = 1'b0;
    mem_wr     = 1'b0;
    if_done    = 1'b0;
    d_done     = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant      = 1'b1;
          next_state = ACCESS;
          grant_sel  = (d_req && (!if_req || last_grant == FETCH)) ? DATA : FETCH;
        end
      end
      ACCESS: begin
        busy   = 1'b1;
        mem_wr = we_q;
        if (cnt_zero) next_state = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        if_done    = (last_grant == FETCH);
        d_done     = (last_grant == DATA);
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Fetches are always reads, so only a data write uses the write latency.
  assign load_value = (grant_sel == DATA && d_we) ? WRITE_LOAD : READ_LOAD;

  mem_wait_counter u_wait (
    .clock      (clock),
    .reset      (reset),
    .load       (grant),
    .load_value (load_value),
    .enable     (state == ACCESS),
    .zero       (cnt_zero)
  );

  // last_grant doubles as the owner of the access in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= FETCH;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if (grant) begin
        last_grant <= grant_sel;
        if (grant_sel == DATA) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          wdata_q <= d_wdata;
        end else begin
          addr_q  <= if_addr;
          we_q    <= 1'b0;
        end
      end
      if (state == ACCESS && cnt_zero && !we_q) begin
        if (last_grant == DATA) d_rdata  <= mem_rdata;
        else                    if_rdata <= mem_rdata;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
